// File: rtl/fp_to_int_converter_if.sv
// Operand and result handshake bundle between an FP producer and fp_to_int_converter.
interface fp_to_int_converter_if #(
  parameter int unsigned OUT_WIDTH = 32
);
  logic [31:0]          input_a;
  logic                 input_a_stb;
  logic                 input_a_ack;
  logic [OUT_WIDTH-1:0] output_z;
  logic [1:0]           output_z_flg;
  logic                 output_z_stb;
  logic                 output_z_ack;

  modport master (
    output input_a, input_a_stb, output_z_ack,
    input  input_a_ack, output_z, output_z_flg, output_z_stb
  );

  modport slave (
    input  input_a, input_a_stb, output_z_ack,
    output input_a_ack, output_z, output_z_flg, output_z_stb
  );
endinterface

// File: rtl/fp_to_int_converter.sv
// Converts a binary32 word to a saturating signed integer (round toward zero)
// with invalid/inexact flags, using the multiplier's stb/ack handshake.
module fp_to_int_converter #(
  parameter int unsigned OUT_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  fp_to_int_converter_if.slave  bus
);

  localparam logic [OUT_WIDTH-1:0] Z_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic [OUT_WIDTH-1:0] Z_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};
  localparam logic signed [9:0]    E_SAT = 10'(OUT_WIDTH - 1);
  localparam logic signed [9:0]    E_M   = 10'sd23;

  typedef enum logic [1:0] {GET_A, UNPACK, CONVERT, PUT_Z} state_t;

  state_t               state_q, state_d;
  logic [31:0]          a_q, a_d;
  logic                 s_q, s_d;
  logic signed [9:0]    e_q, e_d;
  logic [23:0]          m_q, m_d;
  logic                 exp_max_q, exp_max_d;
  logic                 exp_zero_q, exp_zero_d;
  logic                 mant_nz_q, mant_nz_d;
  logic                 ack_q, ack_d;
  logic                 stb_q, stb_d;
  logic [OUT_WIDTH-1:0] z_q, z_d;
  logic [1:0]           flg_q, flg_d;

  logic [63:0]          wide;
  logic [OUT_WIDTH-1:0] mag;
  logic [OUT_WIDTH-1:0] conv_z;
  logic [1:0]           conv_flg;

  // Integer result and flags from the unpacked operand.
  always_comb begin
    wide     = '0;
    mag      = '0;
    conv_z   = '0;
    conv_flg = 2'b00;
    if (e_q >= E_M) wide = 64'(m_q) << (e_q - E_M);
    else            wide = 64'(m_q) >> (E_M - e_q);
    mag = wide[OUT_WIDTH-1:0];
    if (exp_max_q && mant_nz_q) begin
      conv_z   = Z_MIN;
      conv_flg = 2'b10;
    end else if (exp_max_q) begin
      conv_z   = s_q ? Z_MIN : Z_MAX;
      conv_flg = 2'b10;
    end else if (exp_zero_q) begin
      conv_flg = {1'b0, mant_nz_q};
    end else if (e_q[9]) begin
      conv_flg = 2'b01;
    end else if (e_q >= E_SAT) begin
      // -2^(W-1) is the one out-of-range-looking value that is representable
      if (s_q && (e_q == E_SAT) && !mant_nz_q) begin
        conv_z = Z_MIN;
      end else begin
        conv_z   = s_q ? Z_MIN : Z_MAX;
        conv_flg = 2'b10;
      end
    end else begin
      conv_z   = s_q ? -mag : mag;
      conv_flg = {1'b0, (e_q < E_M) && ((wide << (E_M - e_q)) != 64'(m_q))};
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    s_d        = s_q;
    e_d        = e_q;
    m_d        = m_q;
    exp_max_d  = exp_max_q;
    exp_zero_d = exp_zero_q;
    mant_nz_d  = mant_nz_q;
    ack_d      = ack_q;
    stb_d      = stb_q;
    z_d        = z_q;
    flg_d      = flg_q;
    case (state_q)
      GET_A: begin
        ack_d = 1'b1;
        if (bus.input_a_stb && ack_q) begin
          a_d     = bus.input_a;
          ack_d   = 1'b0;
          state_d = UNPACK;
        end
      end
      UNPACK: begin
        s_d        = a_q[31];
        e_d        = $signed({2'b00, a_q[30:23]}) - 10'sd127;
        m_d        = {1'b1, a_q[22:0]};
        exp_max_d  = &a_q[30:23];
        exp_zero_d = ~|a_q[30:23];
        mant_nz_d  = |a_q[22:0];
        state_d    = CONVERT;
      end
      CONVERT: begin
        z_d     = conv_z;
        flg_d   = conv_flg;
        stb_d   = 1'b1;
        state_d = PUT_Z;
      end
      PUT_Z: begin
        if (stb_q && bus.output_z_ack) begin
          stb_d   = 1'b0;
          ack_d   = 1'b1;
          state_d = GET_A;
        end
      end
      default: state_d = GET_A;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= GET_A;
      a_q        <= '0;
      s_q        <= 1'b0;
      e_q        <= '0;
      m_q        <= '0;
      exp_max_q  <= 1'b0;
      exp_zero_q <= 1'b0;
      mant_nz_q  <= 1'b0;
      ack_q      <= 1'b0;
      stb_q      <= 1'b0;
      z_q        <= '0;
      flg_q      <= 2'b00;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      s_q        <= s_d;
      e_q        <= e_d;
      m_q        <= m_d;
      exp_max_q  <= exp_max_d;
      exp_zero_q <= exp_zero_d;
      mant_nz_q  <= mant_nz_d;
      ack_q      <= ack_d;
      stb_q      <= stb_d;
      z_q        <= z_d;
      flg_q      <= flg_d;
    end
  end

  assign bus.input_a_ack  = ack_q;
  assign bus.output_z_stb = stb_q;
  assign bus.output_z     = z_q;
  assign bus.output_z_flg = flg_q;

endmodule
